// File: rtl/bcd_wrap_display_if.sv
// Purpose: bundles the ones-digit input and the display/status outputs of
//   bcd_wrap_display into one port.
// Ports: cnt (ones digit in), tens, carry, err, seg, dig_sel (outputs).
//   master = the side that drives cnt and watches the display;
//   slave  = bcd_wrap_display itself.
interface bcd_wrap_display_if;
  logic [3:0] cnt;
  logic [3:0] tens;
  logic       carry;
  logic       err;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  modport master (output cnt, input tens, input carry, input err, input seg, input dig_sel);
  modport slave  (input cnt, output tens, output carry, output err, output seg, output dig_sel);
endinterface

// File: rtl/bcd_wrap_display.sv
// Purpose: tens-digit tracker and 2-digit multiplexed 7-segment driver fed by
//   a decade counter's ones digit; flags illegal (>9) codes.
// Latency: cnt -> seg 2 cycles (while scanning ONES); wrap -> tens/carry 1 cycle.
// Backpressure: none; free-running, samples cnt every cycle.
// Ports: clk, rst (synchronous, active-low); bus (slave modport): cnt in,
//   tens/carry/err/seg/dig_sel out.
module bcd_wrap_display #(
  parameter int SCAN_DIV       = 50000,
  parameter int TENS_MAX       = 9,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_wrap_display_if.slave    bus
);

  localparam int              PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0]      TMAX    = 4'(TENS_MAX);

  typedef enum logic [1:0] {ONES, BLANK1, TENS, BLANK0} state_t;

  // Active-high gfedcba; anything outside 0..9 decodes to blank.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  logic [3:0]    cnt_q;
  logic [3:0]    tens_q;
  logic          carry_q;
  logic          err_q;
  state_t        state, state_nxt;
  logic [PW-1:0] ps, ps_nxt;
  logic [1:0]    dig_q, dig_nxt;
  logic [6:0]    seg_q, seg_nxt;
  logic          wrap;

  // Only a 9 followed by 0 is a wrap; a 0 after anything else is a counter
  // reset, and an illegal cnt_q can never equal 9.
  assign wrap = (cnt_q == 4'd9) && (bus.cnt == 4'd0);

  // Scan FSM state register; display outputs are registered alongside so they
  // lag the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ONES;
      ps    <= '0;
      dig_q <= 2'b00;
      seg_q <= pol(7'h00);
    end else begin
      state <= state_nxt;
      ps    <= ps_nxt;
      dig_q <= dig_nxt;
      seg_q <= seg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ps_nxt    = ps;
    dig_nxt   = 2'b00;
    seg_nxt   = pol(7'h00);
    case (state)
      ONES: begin
        dig_nxt = 2'b01;
        seg_nxt = pol(decode(cnt_q));
        if (ps == PS_LAST) begin
          ps_nxt    = '0;
          state_nxt = BLANK1;
        end else begin
          ps_nxt = ps + PW'(1);
        end
      end
      BLANK1: begin
        ps_nxt    = '0;
        state_nxt = TENS;
      end
      TENS: begin
        dig_nxt = 2'b10;
        // Leading-zero suppression: the tens digit stays dark at 0.
        seg_nxt = (tens_q == 4'd0) ? pol(7'h00) : pol(decode(tens_q));
        if (ps == PS_LAST) begin
          ps_nxt    = '0;
          state_nxt = BLANK0;
        end else begin
          ps_nxt = ps + PW'(1);
        end
      end
      BLANK0: begin
        ps_nxt    = '0;
        state_nxt = ONES;
      end
      default: begin
        ps_nxt    = '0;
        state_nxt = ONES;
      end
    endcase
  end

  // Input stage, tens digit, carry and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= bus.cnt;
      carry_q <= 1'b0;
      if (wrap) begin
        if (tens_q == TMAX) begin
          tens_q  <= 4'd0;
          carry_q <= 1'b1;
        end else begin
          tens_q  <= tens_q + 4'd1;
        end
      end
      if (bus.cnt > 4'd9) err_q <= 1'b1;
    end
  end

  assign bus.tens    = tens_q;
  assign bus.carry   = carry_q;
  assign bus.err     = err_q;
  assign bus.seg     = seg_q;
  assign bus.dig_sel = dig_q;

endmodule

// File: tb/tb_bcd_wrap_display.sv
// Bench for bcd_wrap_display (SCAN_DIV=4, TENS_MAX=5, active-low segments).
// Stimulus pushes the hand-computed expectation for each clock edge into a
// queue; a monitor pops one entry per cycle and compares the masked fields.
module tb_bcd_wrap_display;

  logic clk = 1'b0;
  logic rst;

  bcd_wrap_display_if bus();

  bcd_wrap_display #(.SCAN_DIV(4), .TENS_MAX(5), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] M_TENS = 5'b00001;
  localparam logic [4:0] M_CRY  = 5'b00010;
  localparam logic [4:0] M_ERR  = 5'b00100;
  localparam logic [4:0] M_SEG  = 5'b01000;
  localparam logic [4:0] M_DIG  = 5'b10000;
  localparam logic [4:0] M_ALL  = 5'b11111;
  localparam logic [4:0] M_CNT  = 5'b00111;

  typedef struct {
    string      tag;
    logic [4:0] m;
    logic [3:0] tens;
    logic       carry;
    logic       err;
    logic [6:0] seg;
    logic [1:0] dig;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Hand-computed segment sequences (active-low) per phase.
  logic [3:0] a_cnt [4]  = '{4'd9, 4'd0, 4'hC, 4'd5};
  logic [6:0] b_seg [11] = '{7'h40, 7'h40, 7'h79, 7'h24, 7'h7F, 7'h7F,
                             7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10};
  logic [3:0] d_cnt [8]  = '{4'd7, 4'd0, 4'hC, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [6:0] d_seg [8]  = '{7'h40, 7'h78, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] f_seg [17] = '{7'h40, 7'h10, 7'h40, 7'h10, 7'h7F, 7'h24, 7'h30, 7'h30,
                             7'h19, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h19,
                             7'h7F};
  logic [6:0] g_seg [6]  = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F};
  logic [1:0] g_dig [6]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};

  // Digit-select sequence after reset release, j = edge number (1-based).
  function automatic logic [1:0] dig_pat(input int j);
    case (j % 10)
      1, 2, 3, 4: return 2'b01;
      6, 7, 8, 9: return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic [3:0] c, input string tag,
                     input logic [4:0] m, input logic [3:0] t, input logic cy,
                     input logic e, input logic [6:0] s, input logic [1:0] d);
    exp_t x;
    rst     = r;
    bus.cnt = c;
    x.tag = tag; x.m = m; x.tens = t; x.carry = cy; x.err = e; x.seg = s; x.dig = d;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string fld,
                       input logic [6:0] act, input logic [6:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", tag, fld, act, expv);
    end
  endtask

  // Monitor: outputs after each edge are compared at the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        if (x.m[0]) check(x.tag, "tens",    7'(bus.tens),    7'(x.tens));
        if (x.m[1]) check(x.tag, "carry",   7'(bus.carry),   7'(x.carry));
        if (x.m[2]) check(x.tag, "err",     7'(bus.err),     7'(x.err));
        if (x.m[3]) check(x.tag, "seg",     bus.seg,         x.seg);
        if (x.m[4]) check(x.tag, "dig_sel", 7'(bus.dig_sel), 7'(x.dig));
      end
    end
  end

  initial begin
    // 1: reset held while cnt toggles (including an illegal code).
    for (int i = 0; i < 4; i++)
      cyc(1'b0, a_cnt[i], "rst_hold", M_ALL, 4'd0, 1'b0, 1'b0, 7'h7F, 2'b00);

    // 2: count 0..9,0; tens increments one cycle after the 0; scan pattern.
    for (int j = 1; j <= 11; j++)
      cyc(1'b1, (j <= 10) ? 4'(j - 1) : 4'd0, "count",
          M_ALL, (j == 11) ? 4'd1 : 4'd0, 1'b0, 1'b0, b_seg[j-1], dig_pat(j));

    // 3: six wraps with TENS_MAX=5; carry on the sixth only.
    cyc(1'b0, 4'd0, "rst_c", M_ALL, 4'd0, 1'b0, 1'b0, 7'h7F, 2'b00);
    for (int k = 1; k <= 13; k++)
      cyc(1'b1, (k % 2 == 1 && k <= 11) ? 4'd9 : 4'd0, "wraps", M_CNT,
          (k >= 12) ? 4'd0 : 4'(k / 2), (k == 12), 1'b0, 7'h00, 2'b00);

    // 4: 7->0 is not a wrap; illegal C sets sticky err and blanks the ones digit.
    cyc(1'b0, 4'd0, "rst_d", M_ALL, 4'd0, 1'b0, 1'b0, 7'h7F, 2'b00);
    for (int j = 1; j <= 8; j++)
      cyc(1'b1, d_cnt[j-1], "illegal", M_ALL, 4'd0, 1'b0, (j >= 3), d_seg[j-1], dig_pat(j));

    // 5: steady cnt=3, tens=0: scan pattern and leading-zero blanking.
    cyc(1'b0, 4'd3, "rst_e", M_ALL, 4'd0, 1'b0, 1'b0, 7'h7F, 2'b00);
    for (int j = 1; j <= 20; j++)
      cyc(1'b1, 4'd3, "scan", M_ALL, 4'd0, 1'b0, 1'b0,
          (dig_pat(j) == 2'b01) ? ((j == 1) ? 7'h40 : 7'h30) : 7'h7F, dig_pat(j));

    // 6: build tens=4, then reset mid-TENS; ONES restarts from a fresh prescaler.
    cyc(1'b0, 4'd0, "rst_f", M_ALL, 4'd0, 1'b0, 1'b0, 7'h7F, 2'b00);
    for (int j = 1; j <= 17; j++)
      cyc((j == 17) ? 1'b0 : 1'b1, (j <= 8 && j % 2 == 1) ? 4'd9 : 4'd0, "tens_mid",
          M_ALL, (j == 17) ? 4'd0 : ((j <= 8) ? 4'(j / 2) : 4'd4), 1'b0, 1'b0,
          f_seg[j-1], (j == 17) ? 2'b00 : dig_pat(j));
    for (int j = 1; j <= 6; j++)
      cyc(1'b1, 4'd0, "resume", M_TENS | M_CRY | M_ERR | M_SEG | M_DIG,
          4'd0, 1'b0, 1'b0, g_seg[j-1], g_dig[j-1]);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
